// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_full_adder_bit.sv
// One-bit full adder built from two half-adder cells and an OR gate.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1, c1, c2;

  // first half adder: a + b
  assign s1 = a ^ b;
  assign c1 = a & b;
  // second half adder: partial sum + carry-in
  assign s  = s1 ^ ci;
  assign c2 = s1 & ci;
  assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell reused over WIDTH
// bit-times, LSB first, with a carry flip-flop between bit-times.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_d;
  logic [WIDTH-1:0] sh_a, sh_b, sh_s;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic             accept, last;

  full_adder_bit u_fa (
    .a  (sh_a[0]),
    .b  (sh_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept = start && (state != ST_RUN);
  assign last   = (state == ST_RUN) && (cnt == LAST);
  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // subtract is A + ~B + 1; cin only matters for add
      sh_a  <= a;
      sh_b  <= (op == OP_SUB) ? ~b : b;
      carry <= (op == OP_SUB) ? 1'b1 : cin;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      sh_a  <= sh_a >> 1;
      sh_b  <= sh_b >> 1;
      sh_s  <= {fa_s, sh_s[WIDTH-1:1]};
      carry <= fa_co;
      if (!last) cnt <= cnt + CW'(1);
      if (last) begin
        // on the MSB bit-time, carry holds the carry into the MSB
        sum  <= {fa_s, sh_s[WIDTH-1:1]};
        cout <= fa_co;
        ovf  <= carry ^ fa_co;
      end
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial add/subtract sequencer that time-shares one 1-bit full-adder cell across WIDTH-bit operands, LSB first, with a carry flip-flop between bit-times. A requester loads the operands with a start pulse. The block runs WIDTH bit-cycles, then presents sum, carry-out and signed overflow with a one-cycle done pulse. It is the area-minimal alternative to a parallel ripple adder built from half-adder cells.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy==0.
op  input  1  0 = A+B+cin, 1 = A-B (B inverted, carry-in forced 1, cin ignored).
cin  input  1  carry-in for add.
a  input  WIDTH  operand A; captured on the accepted start.
b  input  WIDTH  operand B; captured on the accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when the result is valid.
sum  output  WIDTH  result; held stable until the next accepted start.
cout  output  1  final carry (for subtract: 1 = no borrow).
ovf  output  1  two's-complement overflow of the final result.

Behaviour:
- Reset, synchronous at a clk edge with reset==1, takes priority over everything, including mid-operation.
  - Reset state: IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift regs, carry FF and bit counter cleared.
  - An in-flight operation is discarded with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start==1 → RUN. On that edge, load shA=a; load shB = op ? ~b : b; carry FF = op ? 1 : cin; cnt=0; latch op; busy=1.
  - RUN, once per cycle: bit = shA[0]^shB[0]^carry and carry = majority(shA[0],shB[0],carry), both from the full-adder cell.
    - The bit is shifted into sum at the MSB end; shA and shB shift right.
    - On the edge where cnt==WIDTH-1: capture ovf = carry-into-MSB XOR carry-out-of-MSB; cout = new carry; go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
    - start==1 in DONE is accepted exactly as in IDLE (back-to-back allowed).
- Latency: start at edge E0 → bits processed at edges E1..E_WIDTH → done high for the cycle after E_WIDTH. Throughput is one op per WIDTH+1 cycles.
- start while busy==1 (RUN) is ignored; operands are not re-sampled. a, b, op and cin may change freely after the accepting edge.
- sum, cout and ovf update only at the end of RUN; intermediate shifting uses a separate shift register.
  - sum shows the previous result until done; it is never partially updated.
- cnt width is clog2(WIDTH). cnt saturates logic: no wrap occurs inside RUN, since exit is at WIDTH-1.
- ovf is defined for both add and subtract. For add it is computed with cin included.

Decomposition:
- Shared constants header (`include file): FSM state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module, full_adder_bit (a, b, ci → s, co): two half-adder cells plus an OR gate, instantiated once inside serial_add_ctrl.

Test Plan:
- WIDTH=8, op=0, cin=0, a=8'h0F, b=8'h01, 1-cycle start → busy high for 8 cycles; done pulse on the 9th cycle after the start edge; sum=8'h10, cout=0, ovf=0.
- op=0, cin=1, a=8'hFF, b=8'h00 → sum=8'h00, cout=1, ovf=0. Also a=8'h7F, b=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1.
- op=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0 (borrow), ovf=0. Also a=8'h80, b=8'h01 → sum=8'h7F, cout=1, ovf=1.
- Hold start=1 continuously with changing a/b during RUN → the first operands complete unaffected. A new op is accepted in the DONE cycle, and its done arrives exactly 9 cycles after the previous done.
- Assert reset for 1 cycle at bit-cycle 4 of a run → next cycle busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse follows, and a fresh start then completes correctly.
- WIDTH=2 build: a=2'b11, b=2'b01, op=0, cin=0 → sum=2'b00, cout=1, ovf=0, done 3 cycles after start.
